// File: rtl/multdiv_unit_if.sv
// Control/result bundle between the execute-stage control and the multiply/divide unit.
// Latency: none (wires only).
// Backpressure: none; the control side watches busy and data_resultRDY.
interface multdiv_unit_if;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  // Control side: issues start pulses and operands, consumes results.
  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  // Unit side.
  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiplier (radix-2 Booth) and divider (non-restoring).
// Latency: 32 iterations after the accepting edge, plus one DONE cycle; divide special cases finish on the accepting edge.
// Backpressure: starts are ignored while busy; the control must stall on busy and wait for data_resultRDY.
module multdiv_unit (
  input  logic          clock,
  input  logic          reset,
  multdiv_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_cnt;
  // Shared work register: multiply uses {acc[31:0], Q[31:0], q-1},
  // divide uses {rem[32:0], quo[31:0]}.
  logic [64:0] r_work;
  logic [31:0] r_opb;      // multiplicand for multiply, divisor magnitude for divide
  logic        r_neg;      // quotient must be negated at completion
  logic [31:0] r_result;
  logic        r_exc;
  logic        r_rdy;

  logic        w_can_start;
  logic        w_start_mult;
  logic        w_start_div;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic        w_div_special;
  logic        w_last;
  logic [32:0] w_acc_ext;
  logic [32:0] w_m_ext;
  logic [32:0] w_sum;
  logic [64:0] w_booth_nxt;
  logic [32:0] w_shift;
  logic [32:0] w_rem_nxt;
  logic [31:0] w_quo_nxt;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;

  // MULT takes priority when both start pulses arrive together.
  assign w_can_start   = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_start_mult  = w_can_start && bus.ctrl_MULT;
  assign w_start_div   = w_can_start && bus.ctrl_DIV && !bus.ctrl_MULT;
  assign w_div_zero    = (bus.data_operandB == 32'd0);
  assign w_div_ovf     = (bus.data_operandA == 32'h8000_0000) && (bus.data_operandB == 32'hFFFF_FFFF);
  assign w_div_special = w_start_div && (w_div_zero || w_div_ovf);
  assign w_last        = (r_cnt == 6'd31);

  assign w_abs_a = bus.data_operandA[31] ? (32'd0 - bus.data_operandA) : bus.data_operandA;
  assign w_abs_b = bus.data_operandB[31] ? (32'd0 - bus.data_operandB) : bus.data_operandB;

  // Booth step: the add is done one bit wider so a most-negative multiplicand
  // cannot corrupt the sign that the arithmetic shift propagates.
  assign w_acc_ext = {r_work[64], r_work[64:33]};
  assign w_m_ext   = {r_opb[31], r_opb};

  // Booth recoding of {Q[0], q-1} selects add, subtract or pass.
  always_comb begin
    w_sum = w_acc_ext;
    case (r_work[1:0])
      2'b01:   w_sum = w_acc_ext + w_m_ext;
      2'b10:   w_sum = w_acc_ext - w_m_ext;
      default: w_sum = w_acc_ext;
    endcase
  end

  // Arithmetic right shift of {sum, Q, q-1}; sum[0] drops into Q's MSB.
  assign w_booth_nxt = {w_sum, r_work[32:1]};

  // Non-restoring step: remainder magnitude stays below the divisor, so the
  // dropped bit rem[32] always equals rem[31].
  assign w_shift   = {r_work[63:32], r_work[31]};
  assign w_rem_nxt = r_work[64] ? (w_shift + {1'b0, r_opb}) : (w_shift - {1'b0, r_opb});
  assign w_quo_nxt = {r_work[30:0], ~w_rem_nxt[32]};

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_mult)       w_state_nxt = S_MULT;
        else if (w_div_special) w_state_nxt = S_DONE;
        else if (w_start_div)   w_state_nxt = S_DIV;
        else                    w_state_nxt = S_IDLE;
      end
      S_MULT:  if (w_last) w_state_nxt = S_DONE;
      S_DIV:   if (w_last) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand load on accept, one iteration per edge, result capture on entering DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt    <= 6'd0;
      r_work   <= 65'd0;
      r_opb    <= 32'd0;
      r_neg    <= 1'b0;
      r_result <= 32'd0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_mult) begin
            r_cnt  <= 6'd0;
            r_opb  <= bus.data_operandA;
            r_work <= {32'd0, bus.data_operandB, 1'b0};
          end else if (w_start_div) begin
            r_cnt <= 6'd0;
            if (w_div_special) begin
              r_result <= w_div_zero ? 32'd0 : 32'h8000_0000;
              r_exc    <= 1'b1;
            end else begin
              r_opb  <= w_abs_b;
              r_neg  <= bus.data_operandA[31] ^ bus.data_operandB[31];
              r_work <= {33'd0, w_abs_a};
            end
          end
        end
        S_MULT: begin
          r_cnt  <= r_cnt + 6'd1;
          r_work <= w_booth_nxt;
          if (w_last) begin
            r_result <= w_booth_nxt[32:1];
            r_exc    <= (w_booth_nxt[64:33] != {32{w_booth_nxt[32]}});
          end
        end
        S_DIV: begin
          r_cnt  <= r_cnt + 6'd1;
          r_work <= {w_rem_nxt, w_quo_nxt};
          if (w_last) begin
            r_result <= r_neg ? (32'd0 - w_quo_nxt) : w_quo_nxt;
            r_exc    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exc;
  assign bus.data_resultRDY = r_rdy;
  assign bus.busy           = (r_state == S_MULT) || (r_state == S_DIV);

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed cases plus randomized operations
// checked against an arithmetic reference model (64-bit product, truncating divide).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_multdiv_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  multdiv_unit_if u_if();

  multdiv_unit dut (
    .clock (clk),
    .reset (rst),
    .bus   (u_if)
  );

  // Reference: signed product / truncating quotient, special divide cases, expected latency.
  function automatic void ref_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e, output int lat);
    longint p;
    int     q;
    if (is_mult) begin
      p   = longint'(int'(a)) * longint'(int'(b));
      r   = p[31:0];
      e   = (p[63:32] != {32{p[31]}});
      lat = 32;
    end else if (b == 32'd0) begin
      r = 32'd0; e = 1'b1; lat = 0;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000; e = 1'b1; lat = 0;
    end else begin
      q   = int'(a) / int'(b);
      r   = q;
      e   = 1'b0;
      lat = 32;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a start for one cycle; operands are scrambled afterwards.
  task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    u_if.ctrl_MULT     = m;
    u_if.ctrl_DIV      = d;
    u_if.data_operandA = a;
    u_if.data_operandB = b;
    step();
    u_if.ctrl_MULT     = 1'b0;
    u_if.ctrl_DIV      = 1'b0;
    u_if.data_operandA = $urandom;
    u_if.data_operandB = $urandom;
  endtask

  // Count edges until data_resultRDY is seen (bounded), and cycles with busy high before it.
  task automatic wait_rdy(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!u_if.data_resultRDY && lat < 200) begin
      if (u_if.busy) busy_cnt++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_checks++; if (u_if.data_result !== 32'd0) begin n_errors++; $display("FAIL reset_result: got %h want 0", u_if.data_result); end
    n_checks++; if (u_if.data_exception !== 1'b0) begin n_errors++; $display("FAIL reset_exc: got %b want 0", u_if.data_exception); end
    n_checks++; if (u_if.data_resultRDY !== 1'b0) begin n_errors++; $display("FAIL reset_rdy: got %b want 0", u_if.data_resultRDY); end
    n_checks++; if (u_if.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", u_if.busy); end
    step();
    rst = 1'b0;
    step();
    step();
    n_checks++; if (u_if.busy !== 1'b0 || u_if.data_resultRDY !== 1'b0) begin
      n_errors++; $display("FAIL idle_after_reset: busy %b rdy %b want 0 0", u_if.busy, u_if.data_resultRDY);
    end
  endtask

  task automatic test_mult();
    logic [31:0] a, b, er;
    logic        ee;
    int          lat, bc;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin a = 32'd7;        b = 32'd6;        er = 32'd42;        ee = 1'b0; end
        1:       begin a = 32'h0001_0000; b = 32'h0001_0000; er = 32'd0;         ee = 1'b1; end
        default: begin a = 32'hFFFF_FFFD; b = 32'd5;        er = 32'hFFFF_FFF1; ee = 1'b0; end
      endcase
      start_op(1'b1, 1'b0, a, b);
      wait_rdy(lat, bc);
      n_checks++; if (lat !== 32) begin n_errors++; $display("FAIL mult%0d_latency: got %0d want 32", i, lat); end
      n_checks++; if (bc !== 32) begin n_errors++; $display("FAIL mult%0d_busy_cycles: got %0d want 32", i, bc); end
      n_checks++; if (u_if.busy !== 1'b0) begin n_errors++; $display("FAIL mult%0d_busy_at_rdy: got %b want 0", i, u_if.busy); end
      n_checks++; if (u_if.data_result !== er) begin n_errors++; $display("FAIL mult%0d_result: got %h want %h", i, u_if.data_result, er); end
      n_checks++; if (u_if.data_exception !== ee) begin n_errors++; $display("FAIL mult%0d_exc: got %b want %b", i, u_if.data_exception, ee); end
      step();
      n_checks++; if (u_if.data_resultRDY !== 1'b0) begin n_errors++; $display("FAIL mult%0d_rdy_pulse_width: got %b want 0", i, u_if.data_resultRDY); end
      n_checks++; if (u_if.data_result !== er) begin n_errors++; $display("FAIL mult%0d_result_held: got %h want %h", i, u_if.data_result, er); end
    end
  endtask

  task automatic test_div();
    logic [31:0] a, b, er;
    int          lat, bc;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin a = 32'hFFFF_FFF9; b = 32'd2;        er = 32'hFFFF_FFFD; end
      else        begin a = 32'd100;      b = 32'hFFFF_FFF6; er = 32'hFFFF_FFF6; end
      start_op(1'b0, 1'b1, a, b);
      wait_rdy(lat, bc);
      n_checks++; if (lat !== 32) begin n_errors++; $display("FAIL div%0d_latency: got %0d want 32", i, lat); end
      n_checks++; if (u_if.data_result !== er) begin n_errors++; $display("FAIL div%0d_result: got %h want %h", i, u_if.data_result, er); end
      n_checks++; if (u_if.data_exception !== 1'b0) begin n_errors++; $display("FAIL div%0d_exc: got %b want 0", i, u_if.data_exception); end
      step();
    end
  endtask

  task automatic test_div_special();
    logic [31:0] a, b, er;
    int          lat, bc;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin a = 32'd5;         b = 32'd0;         er = 32'd0;         end
      else        begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; er = 32'h8000_0000; end
      start_op(1'b0, 1'b1, a, b);
      wait_rdy(lat, bc);
      n_checks++; if (lat !== 0) begin n_errors++; $display("FAIL divspec%0d_latency: got %0d want 0", i, lat); end
      n_checks++; if (u_if.busy !== 1'b0) begin n_errors++; $display("FAIL divspec%0d_busy: got %b want 0", i, u_if.busy); end
      n_checks++; if (u_if.data_result !== er) begin n_errors++; $display("FAIL divspec%0d_result: got %h want %h", i, u_if.data_result, er); end
      n_checks++; if (u_if.data_exception !== 1'b1) begin n_errors++; $display("FAIL divspec%0d_exc: got %b want 1", i, u_if.data_exception); end
      step();
      n_checks++; if (u_if.data_resultRDY !== 1'b0 || u_if.busy !== 1'b0) begin
        n_errors++; $display("FAIL divspec%0d_after: rdy %b busy %b want 0 0", i, u_if.data_resultRDY, u_if.busy);
      end
    end
  endtask

  task automatic test_protocol();
    int lat, bc;
    // Both starts together: multiply wins.
    start_op(1'b1, 1'b1, 32'd9, 32'd3);
    wait_rdy(lat, bc);
    n_checks++; if (lat !== 32) begin n_errors++; $display("FAIL both_latency: got %0d want 32", lat); end
    n_checks++; if (u_if.data_result !== 32'd27) begin n_errors++; $display("FAIL both_result: got %h want %h", u_if.data_result, 32'd27); end
    step();
    // Divide pulse in the middle of a multiply is ignored.
    start_op(1'b1, 1'b0, 32'd9, 32'd3);
    repeat (5) step();
    u_if.ctrl_DIV      = 1'b1;
    u_if.data_operandA = 32'd100;
    u_if.data_operandB = 32'd0;
    step();
    u_if.ctrl_DIV = 1'b0;
    wait_rdy(lat, bc);
    n_checks++; if (lat !== 26) begin n_errors++; $display("FAIL middiv_latency: got %0d want 26", lat); end
    n_checks++; if (u_if.data_result !== 32'd27 || u_if.data_exception !== 1'b0) begin
      n_errors++; $display("FAIL middiv_result: got %h/%b want %h/0", u_if.data_result, u_if.data_exception, 32'd27);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, bc;
    start_op(1'b1, 1'b0, 32'd9, 32'd3);
    wait_rdy(lat1, bc);
    n_checks++; if (lat1 !== 32) begin n_errors++; $display("FAIL b2b_first_latency: got %0d want 32", lat1); end
    // Start presented in the DONE cycle.
    start_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
    n_checks++; if (u_if.data_resultRDY !== 1'b0 || u_if.busy !== 1'b1) begin
      n_errors++; $display("FAIL b2b_accept: rdy %b busy %b want 0 1", u_if.data_resultRDY, u_if.busy);
    end
    n_checks++; if (u_if.data_result !== 32'd27) begin n_errors++; $display("FAIL b2b_result_held: got %h want %h", u_if.data_result, 32'd27); end
    wait_rdy(lat2, bc);
    n_checks++; if (lat2 + 1 !== 33) begin n_errors++; $display("FAIL b2b_spacing: got %0d want 33", lat2 + 1); end
    n_checks++; if (u_if.data_result !== 32'hFFFF_FFF2) begin n_errors++; $display("FAIL b2b_second_result: got %h want fffffff2", u_if.data_result); end
    step();
  endtask

  task automatic test_reset_mid();
    int lat, bc, seen;
    start_op(1'b1, 1'b0, 32'd7, 32'd6);
    repeat (10) step();
    rst = 1'b1;
    #1;
    n_checks++; if (u_if.data_result !== 32'd0 || u_if.data_exception !== 1'b0) begin
      n_errors++; $display("FAIL midreset_result: got %h/%b want 0/0", u_if.data_result, u_if.data_exception);
    end
    n_checks++; if (u_if.busy !== 1'b0 || u_if.data_resultRDY !== 1'b0) begin
      n_errors++; $display("FAIL midreset_flags: busy %b rdy %b want 0 0", u_if.busy, u_if.data_resultRDY);
    end
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (u_if.data_resultRDY || u_if.busy) seen++;
      step();
    end
    n_checks++; if (seen !== 0) begin n_errors++; $display("FAIL midreset_no_rdy: got %0d active cycles want 0", seen); end
    start_op(1'b1, 1'b0, 32'hFFFF_FFF8, 32'hFFFF_FFF8);
    wait_rdy(lat, bc);
    n_checks++; if (lat !== 32 || u_if.data_result !== 32'd64) begin
      n_errors++; $display("FAIL midreset_restart: lat %0d result %h want 32 %h", lat, u_if.data_result, 32'd64);
    end
    step();
  endtask

  task automatic test_random();
    logic [31:0] a, b, er;
    logic        ee;
    bit          m;
    int          el, lat, bc, sel;
    for (int i = 0; i < 60; i++) begin
      m   = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = {{16{b[15]}}, b[15:0]};
      else if (sel == 3) a = 32'h8000_0000;
      ref_op(m, a, b, er, ee, el);
      start_op(m, !m, a, b);
      wait_rdy(lat, bc);
      n_checks++; if (lat !== el || u_if.data_result !== er || u_if.data_exception !== ee) begin
        n_errors++;
        $display("FAIL random%0d %s a=%h b=%h: got lat %0d res %h exc %b want lat %0d res %h exc %b",
                 i, m ? "mult" : "div", a, b, lat, u_if.data_result, u_if.data_exception, el, er, ee);
      end
      repeat ($urandom_range(1, 3)) step();
    end
  endtask

  initial begin
    rst                = 1'b1;
    u_if.ctrl_MULT     = 1'b0;
    u_if.ctrl_DIV      = 1'b0;
    u_if.data_operandA = 32'd0;
    u_if.data_operandB = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_div_special();
    test_protocol();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Iterative signed 32-bit multiply/divide unit in the execute stage of the five-stage pipeline. It accepts a one-cycle start pulse from the decode/execute control, runs for a fixed number of cycles while holding `busy`, and then pulses `data_resultRDY`. The pipeline's stall control waits on `busy` to freeze PC/FD/DX. The pipeline converts `data_exception` into the overflow-status `setx` on writeback.

## Interface
Parameters:
- None; datapath width fixed at 32 bits.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `ctrl_MULT` in 1: one-cycle start pulse for multiply.
- `ctrl_DIV` in 1: one-cycle start pulse for divide.
- `data_operandA` in 32: multiplicand / dividend, sampled only on the accepting edge.
- `data_operandB` in 32: multiplier / divisor, sampled only on the accepting edge.
- `data_result` out 32: registered result, held until the next accepted start.
- `data_exception` out 1: registered, valid with `data_result`.
- `data_resultRDY` out 1: registered one-cycle completion pulse.
- `busy` out 1: high while state is MULT or DIV.

## Operation
- States:
  - IDLE: reset state.
  - MULT: 32 iterations.
  - DIV: 32 iterations.
  - DONE: single cycle.
- 6-bit iteration counter is cleared on start and increments once per edge in MULT/DIV.
- Start acceptance:
  - Accepted in IDLE or DONE only; ignored in MULT/DIV.
  - If `ctrl_MULT` and `ctrl_DIV` are both high, MULT wins.
- Multiply:
  - Radix-2 Booth, one add/sub-and-arithmetic-shift per iteration over a 65-bit {acc, Q, q-1} register.
  - `data_result` = product[31:0].
  - `data_exception` = 1 iff product[63:32] is not all copies of product[31].
- Divide:
  - Operands converted to magnitudes at start; non-restoring shift-subtract, one quotient bit per iteration.
  - Quotient negated at completion iff sign(A) ≠ sign(B). Truncation is toward zero; the remainder is discarded.
- Divide special cases, resolved on the accepting edge with no iterations:
  - B = 0: result 0x00000000, exception 1.
  - A = 0x80000000 and B = 0xFFFFFFFF: result 0x80000000, exception 1.
- Transitions:
  - IDLE/DONE to MULT or DIV on an accepted start.
  - Divide special case goes straight to DONE.
  - MULT/DIV to DONE on the edge completing iteration 32.
  - DONE to IDLE with no start, or to MULT/DIV on an accepted start.
- Result update:
  - `data_result`/`data_exception` are written only on the edge entering DONE.
  - Both are unchanged during a new operation until that operation completes.

## Timing
- Reset values (asynchronous, immediate): state IDLE, counter 0, `data_result` 0, `data_exception` 0, `data_resultRDY` 0, `busy` 0.
- Start sampled at edge k:
  - `busy` goes high after edge k.
  - Normal op: completes at edge k+32. `busy` low and `data_resultRDY` high for exactly the cycle between edges k+32 and k+33.
- Divide special case sampled at edge k: `busy` never rises; `data_resultRDY` is high between edges k and k+1.
- `busy` is 0 in the cycle the start pulse is presented; stall control must OR its own issue decode with `busy`.
- Back-to-back: a start presented during the DONE cycle is accepted at edge k+33. `data_resultRDY` falls and `busy` rises on that same edge.
- Reset mid-operation aborts the operation:
  - No `data_resultRDY` pulse.
  - `data_result` clears to 0.
- Start pulses held longer than one cycle are tolerated. After completion, a still-high pulse in DONE is accepted as a new operation; the control must deassert it.

## Test plan
- MULT, A=7, B=6 at edge k -> `busy` high edges k..k+32, `data_resultRDY` high one cycle after edge k+32, result 42, exception 0.
- MULT, A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1; also A=-3, B=5 -> result 0xFFFFFFF1, exception 0.
- DIV, A=-7, B=2 -> result 0xFFFFFFFD, exception 0, `data_resultRDY` one cycle after edge k+32; DIV A=100, B=-10 -> 0xFFFFFFF6.
- DIV special cases:
  - A=5, B=0 -> `data_resultRDY` right after edge k, `busy` never high, result 0, exception 1.
  - A=0x80000000, B=-1 -> result 0x80000000, exception 1.
- Protocol:
  - `ctrl_MULT` and `ctrl_DIV` together with A=9, B=3 -> result 27.
  - `ctrl_DIV` pulsed mid-multiply -> ignored, still result 27.
  - New start in the DONE cycle -> second op completes exactly 33 edges after the first completion.
- Assert `reset` at iteration 10 of a multiply -> all outputs 0 immediately, no `data_resultRDY`; a new start after release completes normally.
